instr_sequencer: RTL

Program-memory fetch stage sitting directly upstream of `cpu`. Holds a small program in internal RAM and presents one instruction at a time on the cpu's `in`. Pulses the cpu's `load` and `s` inputs, then waits for `w` before advancing. Run ends on a HALT word, at end of memory, or on a handshake timeout.

---
 rtl/instr_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Program-memory fetch stage for the cpu: steps through an internal program,
// handing each word to the cpu with a load/start handshake and waiting on cpu_w.
module instr_sequencer #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [15:0]   prog_data,
   input  logic          go,
   input  logic          cpu_w,
   output logic [15:0]   cpu_in,
   output logic          cpu_load,
   output logic          cpu_s,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_EXEC, S_ADVANCE, S_DONE, S_ERROR
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [7:0]    TMO_LIMIT = 8'(TIMEOUT);

   state_t        state, state_nxt;
   logic [15:0]   mem [DEPTH];
   logic [15:0]   ir;
   logic [AW-1:0] pc_q;
   logic [7:0]    cnt_q;
   logic [7:0]    tmo_q;
   logic          is_halt;
   logic          at_last;
   logic          tmo_hit;
   logic          accept_cmd;

   assign is_halt    = (ir[15:13] == 3'b111);
   assign at_last    = (pc_q == LAST_ADDR);
   assign tmo_hit    = ((tmo_q + 8'd1) == TMO_LIMIT);
   assign accept_cmd = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

   // Program RAM is never cleared; writes only land while the sequencer is parked.
   always_ff @(posedge clk) begin
      if (reset && accept_cmd && prog_we)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         pc_q  <= '0;
         ir    <= '0;
         cnt_q <= '0;
         tmo_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (go) begin
                  pc_q  <= '0;
                  cnt_q <= '0;
               end
            end
            S_FETCH: ir <= mem[pc_q];
            S_START: tmo_q <= '0;
            S_EXEC:  if (!cpu_w) tmo_q <= tmo_q + 8'd1;
            S_ADVANCE: begin
               if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
               if (!at_last)       pc_q  <= pc_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode state (and the registered ir) only, never live inputs.
   always_comb begin
      state_nxt = state;
      cpu_load  = 1'b0;
      cpu_s     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            busy      = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            busy = 1'b1;
            if (is_halt) begin
               state_nxt = S_DONE;
            end else begin
               cpu_load  = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            busy      = 1'b1;
            cpu_s     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            busy = 1'b1;
            if (cpu_w)        state_nxt = S_ADVANCE;
            else if (tmo_hit) state_nxt = S_ERROR;
         end
         S_ADVANCE: begin
            busy      = 1'b1;
            state_nxt = at_last ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done = 1'b1;
            if (go) state_nxt = S_FETCH;
         end
         S_ERROR: begin
            err = 1'b1;
            if (go) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign cpu_in      = ir;
   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule
